// File: rtl/sm_reg_display.sv
// Debug register viewer: drives regAddr, snapshots regData and shows it as 8 hex digits on a muxed 7-segment display.
// Optional macro SM_REG_DISPLAY_ADDR_EN: digits 7..6 show the register number, dp marks digit 6, digits 5..0 show regData[23:0].
module sm_reg_display #(
  parameter int SCAN_SHIFT     = 10,
  parameter int HOLD_SHIFT     = 24,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        autoScan,
  input  logic [4:0]  manAddr,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic [7:0]  digitEn,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam logic [7:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {S_ADDR, S_WAIT, S_CAP, S_HOLD} state_t;

  state_t                  state_reg;
  logic [SCAN_SHIFT-1:0]   scan_cnt_reg;
  logic [HOLD_SHIFT-1:0]   hold_cnt_reg;
  logic [2:0]              digit_idx_reg;
  logic [31:0]             disp_data_reg;
  logic [31:0]             frame_data_reg;
  logic [4:0]              auto_addr_reg;
  logic                    auto_q_reg;

  logic                    tick;
  logic                    frame_end;
  logic [7:0]              dig_onehot;
  logic [3:0]              nibble;
  logic [6:0]              seg_hi;
  logic                    dp_lit;
  logic [31:0]             cap_word;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  assign tick      = &scan_cnt_reg;
  assign frame_end = tick && (digit_idx_reg == 3'd7);

  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_dig
    assign dig_onehot[gi] = (digit_idx_reg == 3'(gi));
  end

  assign nibble = frame_data_reg[{digit_idx_reg, 2'b00} +: 4];
  assign seg_hi = hex7(nibble);

`ifdef SM_REG_DISPLAY_ADDR_EN
  assign cap_word = {3'b000, regAddr, regData[23:0]};
  assign dp_lit   = (digit_idx_reg == 3'd6);
`else
  assign cap_word = regData;
  assign dp_lit   = 1'b0;
`endif

  // Scan timing and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_reg  <= '0;
      digit_idx_reg <= 3'd0;
      digitEn       <= DIG_OFF;
      seg           <= SEG_OFF;
      dp            <= DP_OFF;
    end else begin
      scan_cnt_reg <= scan_cnt_reg + SCAN_SHIFT'(1);
      if (tick)
        digit_idx_reg <= digit_idx_reg + 3'd1;
      digitEn <= dig_onehot ^ DIG_OFF;
      seg     <= seg_hi ^ SEG_OFF;
      dp      <= dp_lit ^ DP_OFF;
    end
  end

  // Auto-scan address stepping; the registered copy starts at 1 so that
  // coming out of reset already in auto mode scans from r0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_q_reg    <= 1'b1;
      auto_addr_reg <= 5'd0;
      hold_cnt_reg  <= '0;
    end else begin
      auto_q_reg <= autoScan;
      if (autoScan && !auto_q_reg) begin
        auto_addr_reg <= manAddr;
        hold_cnt_reg  <= '0;
      end else if (autoScan) begin
        hold_cnt_reg <= hold_cnt_reg + HOLD_SHIFT'(1);
        if (&hold_cnt_reg)
          auto_addr_reg <= auto_addr_reg + 5'd1;
      end
    end
  end

  // Capture FSM. The captured word is copied to the shown word only at a
  // frame boundary, so a frame never mixes two register values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_ADDR;
      regAddr        <= 5'd0;
      disp_data_reg  <= 32'd0;
      frame_data_reg <= 32'd0;
    end else begin
      if (frame_end)
        frame_data_reg <= disp_data_reg;
      case (state_reg)
        S_ADDR: begin
          regAddr   <= autoScan ? auto_addr_reg : manAddr;
          state_reg <= S_WAIT;
        end
        S_WAIT: state_reg <= S_CAP;
        S_CAP: begin
          disp_data_reg <= cap_word;
          state_reg     <= S_HOLD;
        end
        default: begin
          if (frame_end)
            state_reg <= S_ADDR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm_reg_display.sv
// Directed bench for sm_reg_display with a small register-file model driving regData.
module tb_sm_reg_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        auto_scan;
  logic [4:0]  man_addr;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic [7:0]  digit_en;
  logic [6:0]  seg;
  logic        dp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign reg_data = {8{reg_addr[3:0]}} ^ 32'h12345678;

  sm_reg_display #(
    .SCAN_SHIFT(2), .HOLD_SHIFT(6), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .autoScan(auto_scan), .manAddr(man_addr),
    .regAddr(reg_addr), .regData(reg_data), .digitEn(digit_en), .seg(seg), .dp(dp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_exp(input logic [3:0] v);
    logic [6:0] hi;
    case (v)
      4'h0: hi = 7'h3F;  4'h1: hi = 7'h06;  4'h2: hi = 7'h5B;  4'h3: hi = 7'h4F;
      4'h4: hi = 7'h66;  4'h5: hi = 7'h6D;  4'h6: hi = 7'h7D;  4'h7: hi = 7'h07;
      4'h8: hi = 7'h7F;  4'h9: hi = 7'h6F;  4'hA: hi = 7'h77;  4'hB: hi = 7'h7C;
      4'hC: hi = 7'h39;  4'hD: hi = 7'h5E;  4'hE: hi = 7'h79;  default: hi = 7'h71;
    endcase
    return ~hi;
  endfunction

  // Waits for digit 0 to become newly selected (next frame start), bounded.
  task automatic wait_frame_start();
    logic [7:0] prev;
    bit found;
    prev  = digit_en;
    found = 1'b0;
    for (int n = 0; n < 80 && !found; n++) begin
      @(negedge clk);
      if (digit_en == 8'hFE && prev != 8'hFE) found = 1'b1;
      prev = digit_en;
    end
    if (!found) check("frame_start_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [31:0] word,
                             input int change_at, input logic [4:0] new_addr);
    logic [7:0] en_exp;
    logic [6:0] sg_exp;
    logic       dp_exp;
    wait_frame_start();
    for (int d = 0; d < 8; d++) begin
      if (d == change_at) man_addr = new_addr;
      en_exp = ~(8'h01 << d);
      sg_exp = seg_exp(word[4*d +: 4]);
`ifdef SM_REG_DISPLAY_ADDR_EN
      dp_exp = (d == 6) ? 1'b0 : 1'b1;
`else
      dp_exp = 1'b1;
`endif
      check({tag, "_en"},  {24'd0, digit_en}, {24'd0, en_exp});
      check({tag, "_seg"}, {25'd0, seg},      {25'd0, sg_exp});
      check({tag, "_dp"},  {31'd0, dp},       {31'd0, dp_exp});
      repeat (4) @(negedge clk);
    end
    $display("frame %s: expected word %h checked", tag, word);
  endtask

  initial begin
    logic [4:0] exp_seq [4];
    logic [4:0] last;
    int cnt;
    bit changed;
    logic [31:0] word17;

    rst_n = 1'b0; auto_scan = 1'b0; man_addr = 5'd5;
    repeat (3) @(negedge clk);
    check("rst_digit_en", {24'd0, digit_en}, 32'h0000_00FF);
    check("rst_seg",      {25'd0, seg},      32'h0000_007F);
    check("rst_dp",       {31'd0, dp},       32'd1);
    check("rst_reg_addr", {27'd0, reg_addr}, 32'd0);
    $display("reset state checked");

    rst_n = 1'b1;
    @(posedge clk); #1;
    check("addr_edge1", {27'd0, reg_addr}, 32'd5);
    @(posedge clk); #1;
    check("en_edge2", {24'd0, digit_en}, 32'h0000_00FE);
    repeat (3) @(posedge clk); #1;
    check("en_edge5", {24'd0, digit_en}, 32'h0000_00FD);
    repeat (4) @(posedge clk); #1;
    check("en_edge9", {24'd0, digit_en}, 32'h0000_00FB);
    $display("digit stepping after release checked");

    // r5: 55555555 ^ 12345678
    check_frame("man5", 32'h4761032D, -1, 5'd0);
    // Switch to r9 at digit 3: the rest of this frame must stay r5.
    check_frame("chg_mid", 32'h4761032D, 3, 5'd9);
    check_frame("man9", 32'h8BADCFE1, -1, 5'd0);

    // Auto-scan from r30, wrapping to r0.
    man_addr = 5'd30; auto_scan = 1'b1;
    exp_seq[0] = 5'd30; exp_seq[1] = 5'd31; exp_seq[2] = 5'd0; exp_seq[3] = 5'd1;
    last = reg_addr;
    for (int i = 0; i < 4; i++) begin
      cnt = 0; changed = 1'b0;
      while (cnt < 200 && !changed) begin
        @(negedge clk);
        cnt++;
        if (reg_addr != last) changed = 1'b1;
      end
      check("auto_addr", {27'd0, reg_addr}, {27'd0, exp_seq[i]});
      if (i > 0) check("auto_dwell", {31'd0, (cnt >= 32 && cnt <= 96)}, 32'd1);
      $display("auto step %0d: regAddr %0d after %0d cycles", i, reg_addr, cnt);
      last = reg_addr;
    end

    // Asynchronous reset mid-frame while in auto mode.
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_digit_en", {24'd0, digit_en}, 32'h0000_00FF);
    check("arst_seg",      {25'd0, seg},      32'h0000_007F);
    check("arst_dp",       {31'd0, dp},       32'd1);
    check("arst_reg_addr", {27'd0, reg_addr}, 32'd0);
    check("arst_auto_addr", {27'd0, dut.auto_addr_reg}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_addr_edge1", {27'd0, reg_addr}, 32'd0);
    repeat (49) @(posedge clk); #1;
    check("arst_addr_edge50", {27'd0, reg_addr}, 32'd0);
    $display("async reset in auto mode checked");

    // Manual r17: data 11111111 ^ 12345678 = 03254769.
    auto_scan = 1'b0; man_addr = 5'd17;
`ifdef SM_REG_DISPLAY_ADDR_EN
    word17 = 32'h11254769;
`else
    word17 = 32'h03254769;
`endif
    wait_frame_start();
    check_frame("man17", word17, -1, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
